ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Shares the single difftest RAMHelper port between the core's instruction-fetch requester and its load/store requester. Sits in SimTop between the core's memory ports and the RAMHelper instance. Converts byte addresses to RAMHelper word indices, sequences each access through a three-state FSM, and returns one response pulse per accepted request. Uses fixed data-side priority with an anti-starvation limit for fetch.

## Interface
Parameters:
- RAM_BASE, 64'h8000_0000: byte address of RAM word 0.
- MAX_MEM_STREAK, 4: consecutive MEM grants allowed while IF waits.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req_valid  in  1  fetch request.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_req_addr  in  64  fetch byte address.
- if_rsp_valid  out  1  one-cycle fetch response strobe.
- if_rsp_data  out  64  fetched doubleword.
- mem_req_valid  in  1  load/store request.
- mem_req_ready  out  1  load/store request accepted this cycle.
- mem_req_wen  in  1  1 = store, 0 = load.
- mem_req_addr  in  64  byte address.
- mem_req_wdata  in  64  store data.
- mem_req_wmask  in  64  store bit mask.
- mem_rsp_valid  out  1  one-cycle response strobe (load data or store ack).
- mem_rsp_data  out  64  load data; 0 for store ack.
- ram_ren  out  1  RAMHelper read enable.
- ram_rIdx  out  64  RAMHelper read index.
- ram_rdata  in  64  RAMHelper read data, valid the cycle after ram_ren.
- ram_wen  out  1  RAMHelper write enable.
- ram_wIdx  out  64  RAMHelper write index.
- ram_wdata  out  64  RAMHelper write data.
- ram_wmask  out  64  RAMHelper write mask.

## Operation
- The FSM has three states: IDLE, ISSUE and RESP.
  - IDLE: go to ISSUE on an accept; otherwise stay.
  - ISSUE: go to RESP unconditionally.
  - RESP: go to ISSUE on an accept; otherwise go to IDLE.
- Accept slot: state is IDLE or RESP.
- Grant rule, evaluated combinationally in the accept slot:
  - MEM is granted if mem_req_valid and not (if_req_valid and streak == MAX_MEM_STREAK).
  - Otherwise IF is granted if if_req_valid.
- The corresponding *_req_ready is driven high only for the granted side. Both readies are never 1 in the same cycle.
- A request is accepted on valid & ready. On accept, the arbiter latches the owner (IF/MEM), wen, the index, wdata and wmask.
- Index = (addr − RAM_BASE) >> 3, computed as a 64-bit difference. addr[2:0] is ignored.
- Out-of-range address (addr < RAM_BASE):
  - No ram_ren and no ram_wen is issued.
  - The response is still produced, with data 0.
- ISSUE:
  - For a read, ram_ren=1 and ram_rIdx=latched index.
  - For a store, ram_wen=1 with ram_wIdx/ram_wdata/ram_wmask from the latches.
  - Otherwise ram_ren and ram_wen are 0.
- RESP:
  - The owner's rsp_valid=1 for exactly one cycle.
  - Read data = ram_rdata passed through combinationally, muxed by the latched owner.
  - The non-owner's rsp_valid is 0.
- The requesters accept responses unconditionally; there is no response backpressure.
- Streak counter (3 bits, saturating at MAX_MEM_STREAK):
  - +1 on a MEM grant while if_req_valid=1.
  - Cleared on an IF grant, and in any cycle with if_req_valid=0.

## Timing
- Accept in cycle N:
  - RAM access in N+1.
  - Response strobe in N+2.
  - The next accept is possible in N+2.
- Peak throughput is one access per 2 cycles.
- Reset (asynchronous, active-high):
  - State goes to IDLE, streak to 0, and all latches to 0.
  - All outputs are 0, including both readies.
- Reset mid-operation: the in-flight transaction is dropped. No response is ever produced, and no RAM write occurs after reset asserts.
- Simultaneous IF and MEM valid with streak below the limit: MEM is granted and IF holds valid. The IF request must stay stable until it is accepted.
- A requester dropping valid before acceptance is legal. Nothing is latched.

## Structure
- defines.v holds:
  - `RAM_BASE default.
  - State encodings: `ARB_IDLE=2'd0, `ARB_ISSUE=2'd1, `ARB_RESP=2'd2.
  - Owner encoding: `OWN_IF=1'b0, `OWN_MEM=1'b1.
- One sub-module, ram_arb_pick: combinational grant logic taking both valids, the streak and the accept slot, returning grant_if and grant_mem. It is instantiated once.
- The top level contains the FSM, the streak counter, the request latches and the response mux.

## Test plan
- Single IF read at 0x8000_0010, with RAM word 2 = 0xDEAD_BEEF_0000_0001:
  - ram_ren in N+1 with ram_rIdx=2.
  - if_rsp_valid in N+2 with if_rsp_data=0xDEAD_BEEF_0000_0001.
- MEM store to 0x8000_0008 with wdata=0x1234, wmask=0xFFFF:
  - ram_wen in N+1 with wIdx=1.
  - mem_rsp_valid in N+2 with data 0.
  - A following load of the same address returns 0x1234.
- IF and MEM valid continuously:
  - Grant order is M,M,M,M,I, repeating.
  - if_req_ready and mem_req_ready are never both 1.
- Back-to-back MEM loads: accepts in cycles N and N+2, with response strobes in N+2 and N+4.
- Load from 0x0000_1000 (below base):
  - ram_ren stays 0.
  - mem_rsp_valid in N+2 with data 0.
- reset asserted during ISSUE of a store:
  - ram_wen drops immediately.
  - No mem_rsp_valid afterward.
  - All outputs are 0 until the next accept after reset releases.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types and defaults for the RAMHelper arbiter.
package ram_arbiter_pkg;

  localparam logic [63:0] RAM_BASE_DEFAULT = 64'h8000_0000;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arbState_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational grant: data side wins unless fetch has waited through the streak limit.
module ram_arb_pick
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned MAX_MEM_STREAK = 4
) (
  input  logic       if_valid,
  input  logic       mem_valid,
  input  logic [2:0] streak,
  input  logic       accept_slot,
  output logic       grant_if,
  output logic       grant_mem
);

  localparam logic [2:0] STREAK_LIMIT = 3'(MAX_MEM_STREAK);

  always_comb begin
    grant_mem = accept_slot && mem_valid && !(if_valid && (streak == STREAK_LIMIT));
    grant_if  = accept_slot && if_valid && !grant_mem;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAMHelper port between fetch and load/store; one access per two cycles.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter logic [63:0] RAM_BASE       = RAM_BASE_DEFAULT,
  parameter int unsigned MAX_MEM_STREAK = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_req_addr,
  output logic        if_rsp_valid,
  output logic [63:0] if_rsp_data,
  input  logic        mem_req_valid,
  output logic        mem_req_ready,
  input  logic        mem_req_wen,
  input  logic [63:0] mem_req_addr,
  input  logic [63:0] mem_req_wdata,
  input  logic [63:0] mem_req_wmask,
  output logic        mem_rsp_valid,
  output logic [63:0] mem_rsp_data,
  output logic        ram_ren,
  output logic [63:0] ram_rIdx,
  input  logic [63:0] ram_rdata,
  output logic        ram_wen,
  output logic [63:0] ram_wIdx,
  output logic [63:0] ram_wdata,
  output logic [63:0] ram_wmask
);

  localparam logic [2:0] STREAK_LIMIT = 3'(MAX_MEM_STREAK);

  arbState_t   state, nextState;
  owner_t      owner;
  logic        latWen, latInRange;
  logic [63:0] latIdx, latWdata, latWmask;
  logic [2:0]  streak;

  logic        acceptSlot, grantIf, grantMem, acceptIf, acceptMem, accept;
  logic [63:0] reqAddr, reqDiff;
  logic        rdHit;

  // Readies are gated by reset so both read 0 while reset is held.
  assign acceptSlot = !reset && ((state == ARB_IDLE) || (state == ARB_RESP));

  ram_arb_pick #(.MAX_MEM_STREAK(MAX_MEM_STREAK)) pick (
    .if_valid   (if_req_valid),
    .mem_valid  (mem_req_valid),
    .streak     (streak),
    .accept_slot(acceptSlot),
    .grant_if   (grantIf),
    .grant_mem  (grantMem)
  );

  assign if_req_ready  = grantIf;
  assign mem_req_ready = grantMem;
  assign acceptIf      = grantIf && if_req_valid;
  assign acceptMem     = grantMem && mem_req_valid;
  assign accept        = acceptIf || acceptMem;
  assign reqAddr       = acceptMem ? mem_req_addr : if_req_addr;
  assign reqDiff       = reqAddr - RAM_BASE;

  always_comb begin
    nextState = state;
    case (state)
      ARB_IDLE:  if (accept) nextState = ARB_ISSUE;
      ARB_ISSUE: nextState = ARB_RESP;
      ARB_RESP:  nextState = accept ? ARB_ISSUE : ARB_IDLE;
      default:   nextState = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ARB_IDLE;
      owner      <= OWN_IF;
      latWen     <= 1'b0;
      latInRange <= 1'b0;
      latIdx     <= '0;
      latWdata   <= '0;
      latWmask   <= '0;
      streak     <= '0;
    end else begin
      state <= nextState;
      if (accept) begin
        owner      <= acceptMem ? OWN_MEM : OWN_IF;
        latWen     <= acceptMem && mem_req_wen;
        latInRange <= (reqAddr >= RAM_BASE);
        latIdx     <= reqDiff >> 3;
        latWdata   <= acceptMem ? mem_req_wdata : '0;
        latWmask   <= acceptMem ? mem_req_wmask : '0;
      end
      if (!if_req_valid || acceptIf)
        streak <= '0;
      else if (acceptMem && (streak < STREAK_LIMIT))
        streak <= streak + 3'd1;
    end
  end

  always_comb begin
    ram_ren   = (state == ARB_ISSUE) && !latWen && latInRange;
    ram_wen   = (state == ARB_ISSUE) && latWen && latInRange;
    ram_rIdx  = ram_ren ? latIdx : '0;
    ram_wIdx  = ram_wen ? latIdx : '0;
    ram_wdata = ram_wen ? latWdata : '0;
    ram_wmask = ram_wen ? latWmask : '0;
  end

  assign rdHit = (state == ARB_RESP) && !latWen && latInRange;

  always_comb begin
    if_rsp_valid  = (state == ARB_RESP) && (owner == OWN_IF);
    mem_rsp_valid = (state == ARB_RESP) && (owner == OWN_MEM);
    if_rsp_data   = (if_rsp_valid && rdHit) ? ram_rdata : '0;
    mem_rsp_data  = (mem_rsp_valid && rdHit) ? ram_rdata : '0;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small RAMHelper model.
module tb_ram_arbiter;

  logic        clock, reset;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [63:0] if_req_addr, if_rsp_data;
  logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid;
  logic [63:0] mem_req_addr, mem_req_wdata, mem_req_wmask, mem_rsp_data;
  logic        ram_ren, ram_wen;
  logic [63:0] ram_rIdx, ram_rdata, ram_wIdx, ram_wdata, ram_wmask;

  int checks = 0;
  int failures = 0;

  ram_arbiter #(.RAM_BASE(64'h8000_0000), .MAX_MEM_STREAK(4)) dut (
    .clock(clock), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .ram_ren(ram_ren), .ram_rIdx(ram_rIdx), .ram_rdata(ram_rdata),
    .ram_wen(ram_wen), .ram_wIdx(ram_wIdx), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAMHelper model: 16 words, registered read, masked write.
  logic [63:0] ramModel [16];
  logic        initDone = 1'b0;
  always @(posedge clock) begin
    if (!initDone) begin
      for (int k = 0; k < 16; k++) ramModel[k] <= '0;
      ramModel[2] <= 64'hDEAD_BEEF_0000_0001;
      ram_rdata   <= '0;
      initDone    <= 1'b1;
    end else begin
      if (ram_ren) ram_rdata <= ramModel[ram_rIdx[3:0]];
      if (ram_wen)
        ramModel[ram_wIdx[3:0]] <= (ramModel[ram_wIdx[3:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    if_req_valid = 1'b1; if_req_addr = '0;
    mem_req_valid = 1'b1; mem_req_wen = 1'b0; mem_req_addr = '0;
    mem_req_wdata = '0; mem_req_wmask = '0;
    step();
    chk("rst_readies", {63'd0, if_req_ready | mem_req_ready}, 64'd0);
    chk("rst_strobes", {60'd0, ram_ren, ram_wen, if_rsp_valid, mem_rsp_valid}, 64'd0);
    chk("rst_data", if_rsp_data | mem_rsp_data | ram_rIdx | ram_wIdx | ram_wdata | ram_wmask, 64'd0);
    if_req_valid = 1'b0; mem_req_valid = 1'b0;
    step();
    reset = 1'b0;
    step();

    // Single fetch of word 2
    if_req_addr = 64'h8000_0010; if_req_valid = 1'b1;
    #1;
    chk("t1_if_ready", if_req_ready, 1);
    chk("t1_mem_ready", mem_req_ready, 0);
    step(); if_req_valid = 1'b0;
    chk("t1_ren", ram_ren, 1);
    chk("t1_ridx", ram_rIdx, 64'd2);
    chk("t1_wen", ram_wen, 0);
    step();
    chk("t1_rsp_valid", if_rsp_valid, 1);
    chk("t1_rsp_data", if_rsp_data, 64'hDEAD_BEEF_0000_0001);
    chk("t1_mem_rsp", mem_rsp_valid, 0);
    step();
    chk("t1_rsp_done", if_rsp_valid, 0);

    // Store to word 1, then load it back in the RESP slot
    mem_req_wen = 1'b1; mem_req_addr = 64'h8000_0008;
    mem_req_wdata = 64'h1234; mem_req_wmask = 64'hFFFF; mem_req_valid = 1'b1;
    #1;
    chk("t2_mem_ready", mem_req_ready, 1);
    step(); mem_req_valid = 1'b0;
    chk("t2_wen", ram_wen, 1);
    chk("t2_widx", ram_wIdx, 64'd1);
    chk("t2_wdata", ram_wdata, 64'h1234);
    chk("t2_wmask", ram_wmask, 64'hFFFF);
    chk("t2_ren", ram_ren, 0);
    step();
    chk("t2_ack", mem_rsp_valid, 1);
    chk("t2_ack_data", mem_rsp_data, 64'd0);
    chk("t2_if_rsp", if_rsp_valid, 0);
    mem_req_wen = 1'b0; mem_req_valid = 1'b1;
    #1;
    chk("t2_ld_ready", mem_req_ready, 1);
    step(); mem_req_valid = 1'b0;
    chk("t2_ld_ren", ram_ren, 1);
    chk("t2_ld_ridx", ram_rIdx, 64'd1);
    step();
    chk("t2_ld_valid", mem_rsp_valid, 1);
    chk("t2_ld_data", mem_rsp_data, 64'h1234);
    step();

    // Back-to-back loads of word 2
    mem_req_addr = 64'h8000_0010; mem_req_valid = 1'b1;
    #1;
    chk("t3_ready_n", mem_req_ready, 1);
    step();
    chk("t3_ready_n1", mem_req_ready, 0);
    step();
    chk("t3_rsp_n2", mem_rsp_valid, 1);
    chk("t3_data_n2", mem_rsp_data, 64'hDEAD_BEEF_0000_0001);
    chk("t3_ready_n2", mem_req_ready, 1);
    step(); mem_req_valid = 1'b0;
    chk("t3_rsp_n3", mem_rsp_valid, 0);
    chk("t3_ren_n3", ram_ren, 1);
    step();
    chk("t3_rsp_n4", mem_rsp_valid, 1);
    step();

    // Both requesters continuously valid: M,M,M,M,I repeating
    if_req_addr = 64'h8000_0010; mem_req_addr = 64'h8000_0008; mem_req_wen = 1'b0;
    if_req_valid = 1'b1; mem_req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic expM;
      expM = ((i % 5) != 4);
      #1;
      chk($sformatf("t4_mem_ready_%0d", i), mem_req_ready, expM);
      chk($sformatf("t4_if_ready_%0d", i), if_req_ready, !expM);
      step();
      chk($sformatf("t4_issue_readies_%0d", i), {62'd0, if_req_ready, mem_req_ready}, 64'd0);
      step();
      chk($sformatf("t4_owner_rsp_%0d", i), {62'd0, mem_rsp_valid, if_rsp_valid},
          expM ? 64'd2 : 64'd1);
    end
    if_req_valid = 1'b0; mem_req_valid = 1'b0;
    step();

    // Load below RAM_BASE
    mem_req_addr = 64'h0000_1000; mem_req_valid = 1'b1;
    #1;
    chk("t5_ready", mem_req_ready, 1);
    step(); mem_req_valid = 1'b0;
    chk("t5_no_ren", ram_ren, 0);
    chk("t5_no_wen", ram_wen, 0);
    step();
    chk("t5_rsp", mem_rsp_valid, 1);
    chk("t5_rsp_data", mem_rsp_data, 64'd0);
    step();

    // Reset during ISSUE of a store to word 3
    mem_req_wen = 1'b1; mem_req_addr = 64'h8000_0018;
    mem_req_wdata = 64'hAAAA; mem_req_wmask = '1; mem_req_valid = 1'b1;
    #1;
    step();
    chk("t6_wen", ram_wen, 1);
    chk("t6_widx", ram_wIdx, 64'd3);
    reset = 1'b1;
    #1;
    chk("t6_wen_drop", ram_wen, 0);
    chk("t6_readies", {62'd0, if_req_ready, mem_req_ready}, 64'd0);
    step();
    chk("t6_no_rsp", {62'd0, mem_rsp_valid, ram_wen}, 64'd0);
    step();
    mem_req_valid = 1'b0; reset = 1'b0;
    step();
    chk("t6_post_strobes", {60'd0, ram_ren, ram_wen, if_rsp_valid, mem_rsp_valid}, 64'd0);
    step();
    chk("t6_post_data", mem_rsp_data | ram_wIdx | ram_wdata | ram_wmask, 64'd0);
    chk("t6_no_write", ramModel[3], 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
